// File: rtl/riscv_branch_pkg.sv
// Shared types and helpers for branch prediction and redirect control.
// Holds the redirect FSM encoding and the 2-bit saturating-counter update.
package riscv_branch_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRedirect = 2'd1,
    StDrain    = 2'd2
  } redir_state_e;

  localparam logic [1:0] CtrSnt = 2'b00;
  localparam logic [1:0] CtrWnt = 2'b01;
  localparam logic [1:0] CtrWt  = 2'b10;
  localparam logic [1:0] CtrSt  = 2'b11;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == CtrSt) ? CtrSt : ctr + 2'd1;
    end else begin
      res = (ctr == CtrSnt) ? CtrSnt : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer with one combinational read port and one
// synchronous read-modify-write update port.
module btb_table
  import riscv_branch_pkg::*;
#(
  parameter int unsigned Xlen    = 32,
  parameter int unsigned Entries = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [Xlen-1:0] rd_pc_i,
  output logic            rd_hit_o,
  output logic [1:0]      rd_ctr_o,
  output logic [Xlen-1:0] rd_target_o,
  input  logic            wr_en_i,
  input  logic [Xlen-1:0] wr_pc_i,
  input  logic            wr_taken_i,
  input  logic [Xlen-1:0] wr_target_i
);

  localparam int unsigned IdxW = $clog2(Entries);
  localparam int unsigned TagW = Xlen - IdxW - 2;

  logic            valid_q  [Entries];
  logic [1:0]      ctr_q    [Entries];
  logic [TagW-1:0] tag_q    [Entries];
  logic [Xlen-1:0] target_q [Entries];

  logic [IdxW-1:0] rd_idx;
  logic [TagW-1:0] rd_tag;
  logic [IdxW-1:0] wr_idx;
  logic [TagW-1:0] wr_tag;
  logic            wr_hit;
  logic            unused_pc;

  assign rd_idx    = rd_pc_i[IdxW+1:2];
  assign rd_tag    = rd_pc_i[Xlen-1:IdxW+2];
  assign wr_idx    = wr_pc_i[IdxW+1:2];
  assign wr_tag    = wr_pc_i[Xlen-1:IdxW+2];
  assign unused_pc = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  // Reads see the pre-update contents; there is no write-to-read bypass.
  assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_ctr_o    = ctr_q[rd_idx];
  assign rd_target_o = target_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CtrWnt;
      end
    end else if (wr_en_i) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken_i);
      end else if (wr_taken_i) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= CtrWt;
      end
    end
  end

  // A taken resolve rewrites tag and target on both hit and allocate; on a hit the tag is unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en_i && wr_taken_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target_i;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Control-flow resolution for the 5-stage core: IF-stage BTB prediction, MEM-stage
// mispredict detection, registered redirect/flush, wrong-path drain and perf counters.
module branch_redirect_ctrl
  import riscv_branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned FLUSH_DEPTH = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic [XLEN-1:0] i_if_pc,
  output logic            o_if_pred_taken,
  output logic [XLEN-1:0] o_if_pred_target,
  input  logic            i_mem_valid,
  input  logic            i_mem_branch,
  input  logic            i_mem_PCSrc,
  input  logic [XLEN-1:0] i_mem_pc,
  input  logic [XLEN-1:0] i_mem_target,
  input  logic            i_mem_pred_taken,
  input  logic [XLEN-1:0] i_mem_pred_target,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic [31:0]     o_branch_cnt,
  output logic [31:0]     o_mispred_cnt
);

  localparam int unsigned DrainW    = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH - 1) : 1;
  localparam int unsigned DrainLoad = (FLUSH_DEPTH >= 2) ? FLUSH_DEPTH - 2 : 0;

  redir_state_e      state_q;
  logic              redirect_q;
  logic              flush_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic [DrainW-1:0] drain_cnt_q;
  logic [31:0]       branch_cnt_q;
  logic [31:0]       mispred_cnt_q;

  logic            if_hit;
  logic [1:0]      if_ctr;
  logic [XLEN-1:0] if_target;
  logic            resolve;
  logic            mispredict;
  logic [XLEN-1:0] correct_pc;
  logic            unused_ctr;

  btb_table #(
    .Xlen    (XLEN),
    .Entries (BTB_ENTRIES)
  ) u_btb (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .rd_pc_i     (i_if_pc),
    .rd_hit_o    (if_hit),
    .rd_ctr_o    (if_ctr),
    .rd_target_o (if_target),
    .wr_en_i     (resolve),
    .wr_pc_i     (i_mem_pc),
    .wr_taken_i  (i_mem_PCSrc),
    .wr_target_i (i_mem_target)
  );

  assign unused_ctr       = if_ctr[0];
  assign o_if_pred_taken  = if_hit & if_ctr[1];
  assign o_if_pred_target = o_if_pred_taken ? if_target : '0;

  // Stalled or wrong-path (non-idle) resolves are not events; a stalled one is retried later.
  assign resolve    = i_mem_valid & i_mem_branch & ~i_stall & (state_q == StIdle);
  assign mispredict = (i_mem_PCSrc != i_mem_pred_taken) |
                      (i_mem_PCSrc & i_mem_pred_taken & (i_mem_target != i_mem_pred_target));
  assign correct_pc = i_mem_PCSrc ? i_mem_target : (i_mem_pc + XLEN'(4));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      drain_cnt_q   <= '0;
    end else if (!i_stall) begin
      case (state_q)
        StIdle: begin
          if (resolve && mispredict) begin
            redirect_pc_q <= correct_pc;
            redirect_q    <= 1'b1;
            flush_q       <= 1'b1;
            state_q       <= StRedirect;
          end
        end
        StRedirect: begin
          redirect_q <= 1'b0;
          flush_q    <= 1'b0;
          if (FLUSH_DEPTH == 1) begin
            state_q <= StIdle;
          end else begin
            state_q     <= StDrain;
            drain_cnt_q <= DrainW'(DrainLoad);
          end
        end
        StDrain: begin
          if (drain_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            drain_cnt_q <= drain_cnt_q - DrainW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (resolve) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign o_redirect    = redirect_q;
  assign o_flush       = flush_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios followed by random traffic, all
// checked against an address-level BTB model and a busy-cycle redirect model.
module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned FD      = 3;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_stall;
  logic [XLEN-1:0] i_if_pc;
  logic            o_if_pred_taken;
  logic [XLEN-1:0] o_if_pred_target;
  logic            i_mem_valid;
  logic            i_mem_branch;
  logic            i_mem_PCSrc;
  logic [XLEN-1:0] i_mem_pc;
  logic [XLEN-1:0] i_mem_target;
  logic            i_mem_pred_taken;
  logic [XLEN-1:0] i_mem_pred_target;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_pc;
  logic            o_flush;
  logic [31:0]     o_branch_cnt;
  logic [31:0]     o_mispred_cnt;

  always #5 i_clk = ~i_clk;

  branch_redirect_ctrl #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (ENTRIES),
    .FLUSH_DEPTH (FD)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_stall           (i_stall),
    .i_if_pc           (i_if_pc),
    .o_if_pred_taken   (o_if_pred_taken),
    .o_if_pred_target  (o_if_pred_target),
    .i_mem_valid       (i_mem_valid),
    .i_mem_branch      (i_mem_branch),
    .i_mem_PCSrc       (i_mem_PCSrc),
    .i_mem_pc          (i_mem_pc),
    .i_mem_target      (i_mem_target),
    .i_mem_pred_taken  (i_mem_pred_taken),
    .i_mem_pred_target (i_mem_pred_target),
    .o_redirect        (o_redirect),
    .o_redirect_pc     (o_redirect_pc),
    .o_flush           (o_flush),
    .o_branch_cnt      (o_branch_cnt),
    .o_mispred_cnt     (o_mispred_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: each slot remembers the full word address it holds, so a hit is an exact address match.
  bit          m_valid [ENTRIES];
  logic [31:0] m_key   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          blocked;   // unstalled cycles left during which resolves are ignored
  logic [31:0] m_rpc;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  logic [31:0] pc_pool  [6] = '{32'h40, 32'h440, 32'h100, 32'h1C, 32'h3FC, 32'hFFFF_FFFC};
  logic [31:0] tgt_pool [4] = '{32'h80, 32'h200, 32'h1000, 32'h44};

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int s;
    s = slot(pc);
    return m_valid[s] && (m_key[s] == (pc >> 2)) && (m_ctr[s] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[slot(pc)] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
      m_key[i]   = 32'h0;
      m_tgt[i]   = 32'h0;
    end
    blocked = 0;
    m_rpc   = 32'h0;
    m_bcnt  = 32'h0;
    m_mcnt  = 32'h0;
  endtask

  task automatic model_edge();
    int s;
    bit hit;
    bit mis;
    if (i_rst) begin
      model_reset();
    end else if (!i_stall) begin
      if (blocked > 0) begin
        blocked--;
      end else if (i_mem_valid && i_mem_branch) begin
        s   = slot(i_mem_pc);
        hit = m_valid[s] && (m_key[s] == (i_mem_pc >> 2));
        mis = (i_mem_PCSrc != i_mem_pred_taken) ||
              (i_mem_PCSrc && i_mem_pred_taken && (i_mem_target != i_mem_pred_target));
        m_bcnt = m_bcnt + 32'd1;
        if (hit) begin
          if (i_mem_PCSrc) m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          else             m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
          if (i_mem_PCSrc) m_tgt[s] = i_mem_target;
        end else if (i_mem_PCSrc) begin
          m_valid[s] = 1'b1;
          m_key[s]   = i_mem_pc >> 2;
          m_tgt[s]   = i_mem_target;
          m_ctr[s]   = 2;
        end
        if (mis) begin
          m_mcnt  = m_mcnt + 32'd1;
          m_rpc   = i_mem_PCSrc ? i_mem_target : i_mem_pc + 32'd4;
          blocked = FD;
        end
      end
    end
  endtask

  task automatic check_lookup();
    chk("pred_taken", {31'd0, o_if_pred_taken}, {31'd0, m_pred(i_if_pc)});
    chk("pred_target", o_if_pred_target, m_ptgt(i_if_pc));
  endtask

  task automatic check_regs();
    chk("redirect", {31'd0, o_redirect}, {31'd0, blocked == FD});
    chk("flush", {31'd0, o_flush}, {31'd0, blocked == FD});
    chk("redirect_pc", o_redirect_pc, m_rpc);
    chk("branch_cnt", o_branch_cnt, m_bcnt);
    chk("mispred_cnt", o_mispred_cnt, m_mcnt);
  endtask

  // Called at a negedge with inputs already driven.
  task automatic cycle();
    #1;
    check_lookup();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    check_regs();
  endtask

  task automatic mem_idle();
    i_mem_valid       = 1'b0;
    i_mem_branch      = 1'b0;
    i_mem_PCSrc       = 1'b0;
    i_mem_pc          = 32'h0;
    i_mem_target      = 32'h0;
    i_mem_pred_taken  = 1'b0;
    i_mem_pred_target = 32'h0;
  endtask

  // Branch resolve carrying the bench's own prediction for that PC.
  task automatic mem_branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    i_mem_valid       = 1'b1;
    i_mem_branch      = 1'b1;
    i_mem_PCSrc       = taken;
    i_mem_pc          = pc;
    i_mem_target      = tgt;
    i_mem_pred_taken  = m_pred(pc);
    i_mem_pred_target = m_ptgt(pc);
  endtask

  logic [31:0] saved_b;
  logic [31:0] saved_m;
  logic [31:0] rpc;

  initial begin
    i_rst   = 1'b1;
    i_stall = 1'b0;
    i_if_pc = 32'h40;
    mem_idle();
    repeat (2) @(posedge i_clk);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;

    // Reset state
    #1;
    check_lookup();
    check_regs();
    chk("rst_pred_taken", {31'd0, o_if_pred_taken}, 32'd0);
    chk("rst_pred_target", o_if_pred_target, 32'h0);

    // First taken branch at 0x40 with no prediction
    mem_branch(32'h40, 1'b1, 32'h80);
    cycle();
    chk("first_redirect", {31'd0, o_redirect}, 32'd1);
    chk("first_flush", {31'd0, o_flush}, 32'd1);
    chk("first_rpc", o_redirect_pc, 32'h80);
    chk("first_mispred", o_mispred_cnt, 32'd1);
    mem_idle();
    repeat (FD) cycle();
    i_if_pc = 32'h40;
    #1;
    chk("alloc_hit", {31'd0, o_if_pred_taken}, 32'd1);
    chk("alloc_target", o_if_pred_target, 32'h80);

    // Three taken (correctly predicted), then two not-taken
    for (int k = 0; k < 3; k++) begin
      mem_branch(32'h40, 1'b1, 32'h80);
      cycle();
      chk("taken_no_redirect", {31'd0, o_redirect}, 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      mem_branch(32'h40, 1'b0, 32'h80);
      cycle();
      chk("nt_redirect", {31'd0, o_redirect}, 32'd1);
      chk("nt_rpc", o_redirect_pc, 32'h44);
      mem_idle();
      repeat (FD) cycle();
      #1;
      chk("nt_pred", {31'd0, o_if_pred_taken}, (k == 0) ? 32'd1 : 32'd0);
    end

    // Mispredict followed by a stall while redirecting, then a resolve during drain
    i_if_pc = 32'h300;
    mem_branch(32'h100, 1'b1, 32'h200);
    cycle();
    mem_idle();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_redirect_hold", {31'd0, o_redirect}, 32'd1);
      chk("stall_flush_hold", {31'd0, o_flush}, 32'd1);
    end
    i_stall = 1'b0;
    cycle();
    chk("release_redirect", {31'd0, o_redirect}, 32'd0);
    saved_b = m_bcnt;
    saved_m = m_mcnt;
    mem_branch(32'h300, 1'b1, 32'h1000);
    cycle();
    chk("drain_bcnt", o_branch_cnt, saved_b);
    chk("drain_mcnt", o_mispred_cnt, saved_m);
    mem_idle();
    cycle();
    #1;
    chk("drain_no_alloc", {31'd0, o_if_pred_taken}, 32'd0);

    // Correct taken prediction
    saved_b = m_bcnt;
    saved_m = m_mcnt;
    mem_branch(32'h100, 1'b1, 32'h200);
    cycle();
    chk("correct_redirect", {31'd0, o_redirect}, 32'd0);
    chk("correct_flush", {31'd0, o_flush}, 32'd0);
    chk("correct_bcnt", o_branch_cnt, saved_b + 32'd1);
    chk("correct_mcnt", o_mispred_cnt, saved_m);

    // Reset while redirecting
    mem_branch(32'h40, 1'b1, 32'h80);
    cycle();
    chk("pre_rst_redirect", {31'd0, o_redirect}, 32'd1);
    mem_idle();
    i_rst = 1'b1;
    cycle();
    chk("rst_redirect", {31'd0, o_redirect}, 32'd0);
    chk("rst_flush", {31'd0, o_flush}, 32'd0);
    i_rst   = 1'b0;
    i_if_pc = 32'h100;
    #1;
    chk("rst_btb_invalid", {31'd0, o_if_pred_taken}, 32'd0);

    // Branch counter wrap
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    m_bcnt = 32'hFFFF_FFFF;
    chk("preload_bcnt", o_branch_cnt, 32'hFFFF_FFFF);
    mem_branch(32'h40, 1'b0, 32'h80);
    cycle();
    chk("wrap_bcnt", o_branch_cnt, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      i_rst   = ($urandom_range(0, 99) == 0);
      i_stall = ($urandom_range(0, 4) == 0);
      i_if_pc = pc_pool[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) != 0) begin
        mem_branch(pc_pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                   tgt_pool[$urandom_range(0, 3)]);
        if ($urandom_range(0, 9) >= 7) begin
          i_mem_pred_taken  = 1'($urandom_range(0, 1));
          i_mem_pred_target = tgt_pool[$urandom_range(0, 3)];
        end
        i_mem_branch = ($urandom_range(0, 4) != 0);
      end else begin
        mem_idle();
        i_mem_valid = 1'($urandom_range(0, 1));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
